// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline back end.
// Holds the register-index and data-word widths, the memory-wait FSM
// state type, and the default stall-cycle watchdog limit.
package arm_pkg;

  localparam int unsigned DEST_W_DEF    = 4;   // register-file index width
  localparam int unsigned WORD_W        = 32;  // data path width
  localparam int unsigned STALL_MAX_DEF = 16;  // watchdog limit for one access

  // Memory-access tracking FSM: IDLE while the memory stage is Ready,
  // WAIT while an SRAM access is holding it off.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
// Ports:
//   clk  - clock, counts on the rising edge
//   rst  - asynchronous active-high reset to zero
//   clr  - synchronous clear to zero (wins over inc)
//   inc  - count enable; the value sticks at MAX instead of wrapping
//   q    - current count
module sat_counter #(
  parameter int unsigned   W   = 32,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back selector.
// Captures the memory stage result whenever it is Ready (and not flushed),
// selecting load data or the ALU result before the register, and drives the
// register-file write port plus the forwarding unit. It also tracks SRAM
// stall episodes: total stall cycles, retired write-backs, and a sticky
// watchdog flag for any single stall lasting STALL_MAX cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   WB_EN_IN          - write-back enable from the memory stage
//   MEM_R_EN_IN       - instruction is a load (select data_mem_IN)
//   ALU_res_IN        - ALU result
//   data_mem_IN       - load data
//   Dest_IN           - destination register index
//   Ready             - memory stage ready; low while SRAM access in progress
//   flush             - synchronous bubble insert, overrides Ready
//   WB_WB_EN/WB_Dest/WB_Value - register-file write port
//   fwd_valid         - copy of WB_WB_EN for the hazard/forwarding unit
//   stall_cnt         - saturating count of cycles with Ready low
//   retire_cnt        - saturating count of cycles with WB_WB_EN high
//   stall_timeout     - sticky watchdog flag, cleared only by rst
//   mem_busy          - high while the FSM is in WAIT
module mem_wb_stage
  import arm_pkg::*;
#(
  parameter int unsigned DEST_W    = DEST_W_DEF,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic [WORD_W-1:0] ALU_res_IN,
  input  logic [WORD_W-1:0] data_mem_IN,
  input  logic [DEST_W-1:0] Dest_IN,
  input  logic              Ready,
  input  logic              flush,
  output logic              WB_WB_EN,
  output logic [DEST_W-1:0] WB_Dest,
  output logic [WORD_W-1:0] WB_Value,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              stall_timeout,
  output logic              mem_busy
);

  localparam int unsigned RUN_W = $clog2(STALL_MAX + 1);

  // Pipeline register
  logic              wb_en_q,  wb_en_d;
  logic [DEST_W-1:0] dest_q,   dest_d;
  logic [WORD_W-1:0] value_q,  value_d;
  logic              capture;

  assign capture = Ready & ~flush;

  always_comb begin
    wb_en_d = 1'b0;
    dest_d  = dest_q;
    value_d = value_q;
    if (capture) begin
      wb_en_d = WB_EN_IN;
      dest_d  = Dest_IN;
      value_d = MEM_R_EN_IN ? data_mem_IN : ALU_res_IN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      dest_q  <= '0;
      value_q <= '0;
    end else begin
      wb_en_q <= wb_en_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

  // Stall tracking FSM with registered outputs
  mem_state_e       state_q;
  logic             busy_q;
  logic             timeout_q;
  logic [RUN_W-1:0] run_q;
  logic             run_clr;
  logic             run_hits_max;

  // The run counter is zero throughout IDLE, so it only needs clearing when
  // a WAIT episode ends; in IDLE a Ready-low cycle increments it 0 -> 1.
  assign run_clr      = (state_q == WAIT) && Ready;
  assign run_hits_max = !Ready && (run_q == RUN_W'(STALL_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!Ready) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (Ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (run_hits_max) begin
        timeout_q <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W   (RUN_W),
    .MAX (RUN_W'(STALL_MAX))
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (!Ready),
    .q   (run_q)
  );

  // Performance counters
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (!Ready),
    .q   (stall_cnt)
  );

  // Counts on the same edge that loads WB_WB_EN high, so the count already
  // includes the write-back currently presented on the output.
  sat_counter #(
    .W (CNT_W)
  ) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (wb_en_d),
    .q   (retire_cnt)
  );

  assign WB_WB_EN      = wb_en_q;
  assign fwd_valid     = wb_en_q;
  assign WB_Dest       = dest_q;
  assign WB_Value      = value_q;
  assign stall_timeout = timeout_q;
  assign mem_busy      = busy_q;

endmodule
